// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory-stage access controller.
package mem_access_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    RESP = 3'd2,
    ERR  = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam logic [31:0] ERR_RDATA = 32'h0;
  localparam int          CNT_W     = 8;

  // The whole 32-bit word address is compared before any truncation, so
  // aliases such as 0x0001_0005 are rejected rather than wrapping onto word 5.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input int unsigned words);
    return addr < words;
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Saturating wait-cycle counter; o_terminal flags the wait cycle that would
// bring the count to TIMEOUT, so the owner aborts after exactly TIMEOUT waits.
module mem_timeout_counter
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != '1)) begin
      r_count <= r_count + LP_ONE;
    end
  end

  assign o_terminal = i_enable && (r_count == LP_LAST);

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access controller: issues one req/gnt/rvalid transaction per
// load/store, stalls the pipeline while it is outstanding, flags aborts.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MEM_WORDS = 1024,
  parameter int TIMEOUT   = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              DMWEM,
  input  logic              MtoRFSelM,
  input  logic [31:0]       ALUOutM,
  input  logic [31:0]       WriteDataM,
  output logic              MemStall,
  output logic [31:0]       ReadDataM,
  output logic              MemErr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  state_e r_state;
  state_e w_state_next;

  logic w_op;
  logic w_in_range;
  logic w_cnt_clear;
  logic w_cnt_en;
  logic w_timeout;

  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [31:0]       r_read_data;
  logic              r_mem_err;

  assign w_op       = DMWEM | MtoRFSelM;
  assign w_in_range = addr_in_range(ALUOutM, MEM_WORDS);

  mem_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .CLK        (CLK),
    .RST        (RST),
    .i_clear    (w_cnt_clear),
    .i_enable   (w_cnt_en),
    .o_terminal (w_timeout)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // MemStall is decided from state and op only, never from the handshake
  // inputs, so the hazard path does not see memory-side timing.
  // NOTE: every signal written here gets a default first; a path that
  // skipped an assignment would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_cnt_clear  = 1'b0;
    w_cnt_en     = 1'b0;
    MemStall     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_op) begin
          MemStall = 1'b1;
          if (!w_in_range) begin
            w_state_next = ERR;
          end else begin
            w_state_next = REQ;
            w_cnt_clear  = 1'b1;
          end
        end
      end
      REQ: begin
        MemStall = 1'b1;
        if (mem_gnt) begin
          w_state_next = r_mem_we ? DONE : RESP;
          w_cnt_clear  = 1'b1;
        end else begin
          w_cnt_en = 1'b1;
          if (w_timeout) w_state_next = ERR;
        end
      end
      RESP: begin
        MemStall = 1'b1;
        if (mem_rvalid) begin
          w_state_next = DONE;
        end else begin
          w_cnt_en = 1'b1;
          if (w_timeout) w_state_next = ERR;
        end
      end
      ERR: begin
        MemStall     = 1'b1;
        w_state_next = DONE;
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_read_data <= '0;
      r_mem_err   <= 1'b0;
    end else begin
      // ERR always hands over to DONE, so this is a one-cycle pulse there.
      r_mem_err <= (r_state == ERR);
      case (r_state)
        IDLE: begin
          if (w_op && w_in_range) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= DMWEM;
            r_mem_addr  <= ALUOutM[ADDR_W-1:0];
            r_mem_wdata <= WriteDataM;
          end
        end
        REQ: begin
          if (mem_gnt || w_timeout) r_mem_req <= 1'b0;
        end
        RESP: begin
          if (mem_rvalid) r_read_data <= mem_rdata;
        end
        ERR: begin
          r_read_data <= ERR_RDATA;
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign ReadDataM = r_read_data;
  assign MemErr    = r_mem_err;

endmodule
